// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode encodings and FSM states shared by the alu_seq files
package alu_seq_pkg;

  // Opcode values presented on sel
  localparam logic [2:0] OP_XOR  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_MUL5 = 3'd7;

  // Control FSM: MUL detours through RUN/FIX, everything else goes straight to HOLD
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_MUL_FIX = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_mult.sv
// rtl/alu_seq_mult.sv - unsigned shift-add magnitude multiplier, one step per cycle
module alu_seq_mult #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // High half is the accumulator, low half starts as the multiplier and drains out
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;

  // Carry out of the accumulator add is kept and shifted into the MSB
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_addend;

  assign w_addend = r_prod[0] ? {1'b0, r_mcand} : '0;
  assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + w_addend;

  // done marks the cycle whose closing edge performs the final step, so the
  // caller can leave its run state on the same edge the product completes
  assign done    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign product = r_prod;

  // Load operands on start, then one conditional add plus right shift per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_prod  <= {{WIDTH{1'b0}}, mplier};
      r_mcand <= mcand;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_prod <= {w_sum, r_prod[WIDTH-1:1]};
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered signed ALU with handshake, flags and multi-cycle MUL
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                sel,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH-1:0]   y,
  output logic signed [2*WIDTH-1:0] y_full,
  output logic                      flag_z,
  output logic                      flag_n,
  output logic                      flag_v
);

  localparam int W2 = 2 * WIDTH;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic [W2-1:0]    r_full;
  logic             r_z;
  logic             r_n;
  logic             r_v;
  logic             r_neg;

  // Raw bit views of the operands; all arithmetic below is explicit about sign
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [W2-1:0]    w_a_ext;
  logic [W2-1:0]    w_mul5;

  logic             w_accept;
  logic             w_mul_start;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [W2-1:0]    w_prod;
  logic             w_mul_done;

  logic [WIDTH-1:0] w_y;
  logic [W2-1:0]    w_full;
  logic             w_v;

  logic [W2-1:0]    w_fix_full;
  logic [WIDTH-1:0] w_fix_y;
  logic             w_fix_v;

  assign w_a     = a;
  assign w_b     = b;
  assign w_sum   = {w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b};
  assign w_diff  = {w_a[WIDTH-1], w_a} - {w_b[WIDTH-1], w_b};
  assign w_a_ext = {{WIDTH{w_a[WIDTH-1]}}, w_a};
  assign w_mul5  = (w_a_ext << 2) + w_a_ext;

  assign w_accept    = in_valid && r_in_ready;
  assign w_mul_start = w_accept && (sel == OP_MUL);

  // Magnitudes are unsigned WIDTH bits so the most negative value maps to 2^(WIDTH-1)
  assign w_abs_a = w_a[WIDTH-1] ? (WIDTH'(0) - w_a) : w_a;
  assign w_abs_b = w_b[WIDTH-1] ? (WIDTH'(0) - w_b) : w_b;

  alu_seq_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .mcand   (w_abs_a),
    .mplier  (w_abs_b),
    .product (w_prod),
    .done    (w_mul_done)
  );

  // Signed MUL result: apply the latched sign to the unsigned 2W-bit magnitude
  assign w_fix_full = r_neg ? (W2'(0) - w_prod) : w_prod;
  assign w_fix_y    = w_fix_full[WIDTH-1:0];
  assign w_fix_v    = (w_fix_full != {{WIDTH{w_fix_y[WIDTH-1]}}, w_fix_y});

  // Single-cycle result, full-width result and overflow for the non-MUL opcodes
  always_comb begin
    w_y    = '0;
    w_full = '0;
    w_v    = 1'b0;
    case (sel)
      OP_XOR:  w_y = w_a ^ w_b;
      OP_AND:  w_y = w_a & w_b;
      OP_OR:   w_y = w_a | w_b;
      OP_SHR:  w_y = {w_a[WIDTH-1], w_a[WIDTH-1:1]};
      OP_ADD: begin
        w_y = w_sum[WIDTH-1:0];
        w_v = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Overflow of a + (-b): signs of a and -b agree exactly when a and b differ
        w_y = w_diff[WIDTH-1:0];
        w_v = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_MUL5: w_y = w_mul5[WIDTH-1:0];
      default: w_y = '0;
    endcase
    w_full = {{WIDTH{w_y[WIDTH-1]}}, w_y};
    if (sel == OP_ADD) begin
      w_full = {{(WIDTH-1){w_sum[WIDTH]}}, w_sum};
    end else if (sel == OP_SUB) begin
      w_full = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
    end else if (sel == OP_MUL5) begin
      w_full = w_mul5;
      w_v    = (w_mul5 != {{WIDTH{w_y[WIDTH-1]}}, w_y});
    end
  end

  // Control FSM with registered handshake signals and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_full      <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (sel == OP_MUL) begin
              r_neg   <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
              r_state <= ST_MUL_RUN;
            end else begin
              r_y         <= w_y;
              r_full      <= w_full;
              r_z         <= (w_y == '0);
              r_n         <= w_y[WIDTH-1];
              r_v         <= w_v;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_MUL_RUN: begin
          if (w_mul_done) begin
            r_state <= ST_MUL_FIX;
          end
        end
        ST_MUL_FIX: begin
          r_y         <= w_fix_y;
          r_full      <= w_fix_full;
          r_z         <= (w_fix_y == '0);
          r_n         <= w_fix_y[WIDTH-1];
          r_v         <= w_fix_v;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_full    = r_full;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomised checks of alu_seq against an arithmetic model
module tb_alu_seq;

  localparam int W = 6;

  localparam logic [2:0] T_XOR  = 3'd0;
  localparam logic [2:0] T_AND  = 3'd1;
  localparam logic [2:0] T_SHR  = 3'd3;
  localparam logic [2:0] T_ADD  = 3'd4;
  localparam logic [2:0] T_MUL  = 3'd5;
  localparam logic [2:0] T_SUB  = 3'd6;
  localparam logic [2:0] T_MUL5 = 3'd7;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [2:0]     sel = 3'd0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   y;
  logic [2*W-1:0] y_full;
  logic           flag_z;
  logic           flag_n;
  logic           flag_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_full    (y_full),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // True mathematical result, then truncate; overflow = result outside W-bit signed range
  function automatic void model(input logic [2:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                output logic [2*W-1:0] ef, output logic [W-1:0] ey,
                                output logic [2:0] efl);
    int ia;
    int ib;
    int r;
    logic [W-1:0] t;
    ia = $signed(aa);
    ib = $signed(bb);
    case (s)
      3'd0: begin t = aa ^ bb; r = $signed(t); end
      3'd1: begin t = aa & bb; r = $signed(t); end
      3'd2: begin t = aa | bb; r = $signed(t); end
      3'd3: r = ia >>> 1;
      3'd4: r = ia + ib;
      3'd5: r = ia * ib;
      3'd6: r = ia - ib;
      default: r = ia * 5;
    endcase
    ey  = r[W-1:0];
    ef  = r[2*W-1:0];
    efl = {(ey == '0), ey[W-1], ((r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1))};
  endfunction

  // One full transaction; starts and ends just after a falling edge with the DUT idle
  task automatic run_op(input logic [2:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input int stall);
    int w;
    int n_edges;
    logic [2*W-1:0] ef;
    logic [W-1:0]   ey;
    logic [2:0]     efl;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_op", in_ready, 1);
    sel = s;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sel = 3'($urandom);
    a = W'($urandom);
    b = W'($urandom);
    n_edges = 0;
    while (!out_valid && n_edges < 40) begin
      @(negedge clk);
      n_edges++;
    end
    check("latency_edges", n_edges, (s == T_MUL) ? (W + 1) : 0);
    model(s, aa, bb, ef, ey, efl);
    check("y", y, ey);
    check("y_full", y_full, ef);
    check("flags_znv", {flag_z, flag_n, flag_v}, efl);
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid_y_full", {out_valid, y_full}, {1'b1, ef});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid_ready", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int n_out;
    logic [2:0] rs;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_ready_valid", {in_ready, out_valid}, 2'b10);
    check("reset_y_full", y_full, 0);
    check("reset_y_flags", {y, flag_z, flag_n, flag_v}, 0);
    rst = 1'b0;
    @(negedge clk);

    // ADD overflow into the sign bit
    run_op(T_ADD, 6'd31, 6'd1, 0);
    check("add_y", y, 6'h20);
    check("add_znv", {flag_z, flag_n, flag_v}, 3'b011);

    // Most-negative squared: full product needs the unsigned magnitude path
    run_op(T_MUL, 6'h20, 6'h20, 1);
    check("mul_y_full", y_full, 12'h400);
    check("mul_y_znv", {y, flag_z, flag_n, flag_v}, {6'h00, 3'b101});

    // Zero operand still takes the full latency (checked inside run_op)
    run_op(T_MUL, 6'h00, 6'd17, 0);
    check("mul_zero", y_full, 0);

    run_op(T_MUL5, 6'd7, 6'h15, 0);
    check("mul5_y_full", y_full, 12'h023);
    check("mul5_y_znv", {y, flag_z, flag_n, flag_v}, {6'h23, 3'b011});

    run_op(T_SHR, 6'h3B, 6'h3F, 0);
    check("shr_y_znv", {y, flag_z, flag_n, flag_v}, {6'h3D, 3'b010});

    // Backpressure: result held, busy input ignored
    sel = T_SUB;
    a = 6'h3D;
    b = 6'd4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("sub_first", {out_valid, y, y_full}, {1'b1, 6'h39, 12'hFF9});
    for (int i = 0; i < 5; i++) begin
      sel = T_ADD;
      a = 6'd10;
      b = 6'd1;
      in_valid = (i >= 1);
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, y, y_full}, {2'b10, 6'h39, 12'hFF9});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready, y}, {2'b01, 6'h39});
    @(negedge clk);
    check("bp_not_captured", {out_valid, in_ready, y}, {2'b01, 6'h39});

    // Asynchronous reset during the third multiply step
    sel = T_MUL;
    a = 6'h20;
    b = 6'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mul_busy_before_rst", {out_valid, in_ready}, 2'b00);
    #2 rst = 1'b1;
    #1 check("rst_async_ready_valid", {out_valid, in_ready}, 2'b01);
    check("rst_async_y_full", y_full, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(T_AND, 6'h3C, 6'h0F, 0);
    check("and_after_rst", y, 6'h0C);
    repeat (12) @(negedge clk);
    check("no_late_mul", {out_valid, y}, {1'b0, 6'h0C});

    // Sustained throughput with out_ready tied high: one result every two cycles
    sel = T_ADD;
    a = 6'd1;
    b = 6'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n_out = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n_out++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("throughput", n_out, 5);
    check("throughput_y", y, 6'd3);
    @(negedge clk);

    // Every operand pair with a random opcode and random stalls
    for (int i = 0; i < 4096; i++) begin
      rs = 3'($urandom_range(0, 7));
      run_op(rs, i[11:6], i[5:0], $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
